// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared state type, default sizes and index-width helper
// for the SD block-read arbiter.
package sd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 1000000;

   // Width of a client index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: combinational rotate-priority picker. Returns the first
// asserted request at or after ptr, wrapping modulo NUM_REQ.
module sd_rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // ptr and the offset are both below NUM_REQ, so one conditional
   // subtraction is enough to wrap the sum.
   localparam int SUM_W = IDX_W + 1;

   logic [IDX_W-1:0]   cand [NUM_REQ];
   logic [NUM_REQ-1:0] hit;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] sum;
      assign sum      = {1'b0, ptr} + SUM_W'(gi);
      assign cand[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                 : IDX_W'(sum);
      assign hit[gi]  = req[cand[gi]];
   end

   // Smallest offset from the pointer wins; scan downwards so it lands last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            valid = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin sharing of one SD block-read engine between
// NUM_REQ clients, with a level start/done handshake toward the engine and
// a one-cycle ack back to the winning client.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort a read that stays in
// BUSY for TIMEOUT_CYCLES cycles (reported through resp_err).
module sd_read_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        ack,
   output logic [31:0]               resp_data,
   output logic                      resp_err,
   output logic                      busy,
   output logic                      rd_start,
   output logic [ADDR_W-1:0]         rd_addr,
   input  logic [31:0]               rd_data,
   input  logic                      rd_done
);

   localparam int               IDX_W    = idx_w(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   // Elaboration-time guard on the supported configuration range.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("sd_read_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("sd_read_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic                rd_start_q, rd_start_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic                start_grant;
   logic                complete;
   logic                expired;

   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
   end

   sd_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Next-state logic: grant in IDLE, wait for done (or watchdog) in BUSY,
   // and hold off in RELEASE until the engine has dropped done.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      ack_d       = '0;
      resp_data_d = resp_data_q;
      rd_start_d  = rd_start_q;
      rd_addr_d   = rd_addr_q;
      start_grant = 1'b0;
      complete    = 1'b0;
      case (state_q)
         IDLE: begin
            // A done level left over from a previous read blocks new starts.
            if (pick_valid && !rd_done) begin
               start_grant = 1'b1;
               gnt_idx_d   = pick_idx;
               rd_addr_d   = addr_arr[pick_idx];
               rd_start_d  = 1'b1;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (rd_done || expired) begin
               complete          = 1'b1;
               resp_data_d       = rd_done ? rd_data : 32'd0;
               ack_d[gnt_idx_q]  = 1'b1;
               rd_start_d        = 1'b0;
               ptr_d             = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
               state_d           = RELEASE;
            end
         end
         RELEASE: begin
            rd_start_d = 1'b0;
            if (!rd_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            rd_start_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // FSM state and registered outputs; reset drops rd_start at once so the
   // engine falls back to its halt state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         ack_q       <= '0;
         resp_data_q <= '0;
         rd_start_q  <= 1'b0;
         rd_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         ack_q       <= ack_d;
         resp_data_q <= resp_data_d;
         rd_start_q  <= rd_start_d;
         rd_addr_q   <= rd_addr_d;
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             resp_err_q, resp_err_d;

   assign expired = (state_q == BUSY) && (timer_q == TMR_LAST);

   // Watchdog count: cleared on entry to BUSY, one step per BUSY cycle.
   always_comb begin
      timer_d    = timer_q;
      resp_err_d = resp_err_q;
      if (start_grant) begin
         timer_d = '0;
      end else if (state_q == BUSY) begin
         timer_d = timer_q + TMR_W'(1);
      end
      if (complete) begin
         resp_err_d = !rd_done;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         resp_err_q <= resp_err_d;
      end
   end

   assign resp_err = resp_err_q;
`else
   assign expired  = 1'b0;
   assign resp_err = 1'b0;
`endif

   assign ack       = ack_q;
   assign resp_data = resp_data_q;
   assign rd_start  = rd_start_q;
   assign rd_addr   = rd_addr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: directed bench with an SD engine model, a client model
// that drops req on ack, and a scoreboard of expected completions.
`timescale 1ns/1ps
module tb_sd_read_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int TMO = 100;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    ack;
   logic [31:0]     resp_data;
   logic            resp_err;
   logic            busy;
   logic            rd_start;
   logic [AW-1:0]   rd_addr;
   logic [31:0]     rd_data;
   logic            rd_done;

   logic [31:0]     cl_addr [N];
   int              req_cnt [N];

   int eng_lat, eng_hold, eng_tmo;
   bit eng_never, eng_stale, abort_ok;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          client;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   always_comb begin
      req_addr = '0;
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = cl_addr[i];
   end

   sd_read_arbiter #(
      .NUM_REQ        (N),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_addr  (req_addr),
      .ack       (ack),
      .resp_data (resp_data),
      .resp_err  (resp_err),
      .busy      (busy),
      .rd_start  (rd_start),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_done   (rd_done)
   );

   function automatic logic [31:0] word_for(input logic [31:0] a);
      return (a == 32'h0000_0200) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input int c, input bit err);
      exp_t e;
      e.client = c;
      e.addr   = cl_addr[c];
      e.data   = err ? 32'd0 : word_for(cl_addr[c]);
      e.err    = err;
      exp_q.push_back(e);
   endtask

   task automatic request(input int c, input int times);
      req_cnt[c] = times;
      req[c]     = 1'b1;
   endtask

   task automatic wait_quiet(input int budget, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy || req != '0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_complete"}, 64'(n < budget), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   // Engine model: answers eng_lat cycles after start, keeps done high for
   // eng_hold cycles after start drops (at least one).
   initial begin : engine
      typedef enum {E_IDLE, E_RUN, E_DONE} eng_t;
      eng_t        es;
      int          cnt;
      int          h;
      logic [31:0] addr_l;
      es = E_IDLE; cnt = 0; h = 0; addr_l = '0;
      rd_done = 1'b0;
      rd_data = '0;
      forever begin
         @(negedge clk);
         if (es == E_IDLE) begin
            if (rd_start) begin
               check("start_pending", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) check("start_addr", 64'(rd_addr), 64'(exp_q[0].addr));
               addr_l = rd_addr;
               cnt    = 0;
               es     = E_RUN;
            end else begin
               rd_done = eng_stale;
            end
         end
         if (es == E_RUN) begin
            if (rd_start) begin
               check("addr_stable", 64'(rd_addr), 64'(addr_l));
               cnt++;
               if (!eng_never && cnt == eng_lat) begin
                  rd_done = 1'b1;
                  rd_data = word_for(addr_l);
                  h       = 0;
                  es      = E_DONE;
               end
            end else begin
               if (!abort_ok) check("start_hold", 64'(cnt), 64'(eng_tmo));
               rd_done = 1'b0;
               es      = E_IDLE;
            end
         end else if (es == E_DONE) begin
            check("start_low_while_done", 64'(rd_start), 64'd0);
            if (!rd_start) begin
               h++;
               if (h >= eng_hold) begin
                  rd_done = 1'b0;
                  rd_data = 32'h0BAD_0BAD;
                  es      = E_IDLE;
               end
            end
         end
      end
   end

   // Ack monitor, scoreboard pop, client drop-on-ack and RELEASE length.
   initial begin : monitor
      logic [N-1:0] prev_ack;
      int           rel;
      exp_t         e;
      prev_ack = '0;
      rel      = 0;
      forever begin
         @(negedge clk);
         if (ack != '0) begin
            check("ack_onehot", 64'($onehot(ack)), 64'd1);
            check("ack_one_cycle", 64'(prev_ack), 64'd0);
            check("ack_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("ack_client", 64'(ack), 64'(N'(1) << e.client));
               check("resp_data", 64'(resp_data), 64'(e.data));
               check("resp_err", 64'(resp_err), 64'(e.err));
               $display("txn: client %0d addr %08h data %08h err %0b", e.client, e.addr, resp_data, resp_err);
            end
            for (int i = 0; i < N; i++) begin
               if (ack[i]) begin
                  if (req_cnt[i] > 0) req_cnt[i]--;
                  if (req_cnt[i] == 0) req[i] = 1'b0;
               end
            end
         end
         prev_ack = ack;
         if (busy && !rd_start) begin
            rel++;
         end else if (!busy && rel != 0) begin
            check("release_len", 64'(rel), 64'((eng_hold < 1) ? 1 : eng_hold));
            rel = 0;
         end
      end
   end

   initial begin : stim
      req = '0;
      for (int i = 0; i < N; i++) begin
         req_cnt[i] = 0;
         cl_addr[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0100;
      end
      eng_lat = 5; eng_hold = 1; eng_tmo = 0;
      eng_never = 0; eng_stale = 0; abort_ok = 0;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      check("rst_resp_err", 64'(resp_err), 64'd0);
      check("rst_rd_start", 64'(rd_start), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // All four at once from reset: served 0,1,2,3.
      for (int i = 0; i < N; i++) push_exp(i, 1'b0);
      for (int i = 0; i < N; i++) request(i, 1);
      wait_quiet(400, "all_four");

      // Client 0 keeps re-requesting while client 3 waits: 0,3,0,3.
      push_exp(0, 1'b0); push_exp(3, 1'b0); push_exp(0, 1'b0); push_exp(3, 1'b0);
      request(0, 2);
      request(3, 2);
      wait_quiet(400, "alternate");

      // Single client, 20-cycle engine.
      cl_addr[2] = 32'h0000_0200;
      eng_lat = 20;
      push_exp(2, 1'b0);
      request(2, 1);
      wait_quiet(200, "single");
      check("resp_data_held", 64'(resp_data), 64'h0000_0000_DEAD_BEEF);
      eng_lat = 5;

      // Engine keeps done high 3 cycles after start drops.
      eng_hold = 3;
      push_exp(1, 1'b0);
      request(1, 1);
      wait_quiet(200, "done_hold");
      eng_hold = 1;

      // Reset in the middle of BUSY (pointer is 2 here, so client 2 wins).
      push_exp(2, 1'b0);
      request(0, 1);
      request(2, 1);
      begin
         int n = 0;
         while (!rd_start && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("reset_txn_started", 64'(rd_start), 64'd1);
      end
      repeat (2) @(negedge clk);
      abort_ok = 1;
      #2 reset = 1'b1;
      #1;
      check("async_rst_rd_start", 64'(rd_start), 64'd0);
      check("async_rst_ack", 64'(ack), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      push_exp(0, 1'b0);
      push_exp(2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      abort_ok = 0;
      wait_quiet(400, "after_reset");

      // Stale done in IDLE must block the next start.
      eng_stale = 1;
      repeat (2) @(negedge clk);
      push_exp(3, 1'b0);
      request(3, 1);
      repeat (5) begin
         @(negedge clk);
         check("stale_done_no_start", 64'({busy, rd_start}), 64'd0);
      end
      eng_stale = 0;
      wait_quiet(200, "stale_done");

`ifdef SD_ARB_TIMEOUT_EN
      // Engine never answers: watchdog fires after TMO BUSY cycles.
      eng_never = 1;
      eng_tmo   = TMO;
      push_exp(1, 1'b1);
      request(1, 1);
      wait_quiet(400, "timeout");
      eng_never = 0;
      eng_tmo   = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: observed simulation still running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares the single SD block-read engine (CMD17 sequencer) between NUM_REQ clients, e.g. audio streamer, sprite loader and level loader.
- Arbitrates round-robin and latches the winner's address.
- Drives the engine's level-held start/done handshake: start stays high until done, then start drops until done clears.
- Returns the 32-bit read word to the winner with a one-cycle acknowledge.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- ADDR_W, 32, SD address width.
- TIMEOUT_CYCLES, 1000000, watchdog limit in BUSY; used only with SD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-client read request, level, held until ack.
- req_addr  in  NUM_REQ*ADDR_W  flattened per-client addresses; client i occupies bits [i*ADDR_W +: ADDR_W].
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_data  out  32  read word; valid while any ack bit is high, held until the next completion.
- resp_err  out  1  timeout flag; qualified by ack.
- busy  out  1  high in BUSY or RELEASE.
- rd_start  out  1  engine start; level, registered.
- rd_addr  out  ADDR_W  engine address; registered, stable through BUSY.
- rd_data  in  32  engine read data.
- rd_done  in  1  engine done level.

Behaviour:
- Reset values: state IDLE, rr pointer 0, ack 0, resp_data 0, resp_err 0, rd_start 0, rd_addr 0, busy 0. Reset mid-operation drops rd_start immediately, which returns the engine to its halt state. An in-flight request is lost, so clients must re-request.
- IDLE: if req is non-zero, select the first asserted index at or after the pointer, wrapping modulo NUM_REQ. Latch gnt_idx and rd_addr. Set rd_start=1 and go to BUSY. Requests are sampled only in IDLE.
- BUSY: hold rd_start=1. When rd_done=1:
  - register resp_data <= rd_data and resp_err <= 0;
  - set ack[gnt_idx]=1 for exactly one cycle;
  - set rd_start=0;
  - set pointer = (gnt_idx+1) mod NUM_REQ;
  - go to RELEASE.
- RELEASE: rd_start=0. Stay while rd_done=1; go to IDLE on the first cycle with rd_done=0. Minimum one cycle.
- Client rule: drop req on the clock edge where ack is sampled high. The RELEASE cycle guarantees IDLE sees the dropped req, so there is no double service.
- Latency: req high at edge N gives rd_start high after edge N. ack follows one cycle after the engine's done. Minimum back-to-back spacing is 3 cycles plus engine time.
- Simultaneous requests: exactly one grant per transaction. All other requests stay pending and are served in rotating order. No client is starved beyond NUM_REQ-1 other transactions.
- req withdrawn before grant: ignored. req dropped after grant: the read still completes and ack still pulses.
- rd_done high while in IDLE (stale engine state): do not start. Wait in IDLE until rd_done=0.
- busy = (state != IDLE).

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- With it defined:
  - a counter clears on entry to BUSY and increments each BUSY cycle;
  - if the count reaches TIMEOUT_CYCLES-1 with rd_done still 0, drop rd_start, pulse ack[gnt_idx] with resp_err=1 and resp_data=0, advance the pointer, and go to RELEASE.
- Without it: no counter, resp_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package sd_arb_pkg holds:
  - state enum {IDLE, BUSY, RELEASE};
  - default NUM_REQ and ADDR_W constants;
  - IDX_W = $clog2(NUM_REQ) helper.
- Sub-module sd_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector and pointer.
  - Outputs: valid and index.
- The top holds the FSM, registers and watchdog.

Test Plan:
- Single client: req[2]=1, addr 0x0000_0200; engine model returns 0xDEADBEEF after 20 cycles -> rd_addr=0x200 and rd_start held 20 cycles; ack=4'b0100 for 1 cycle with resp_data=0xDEADBEEF.
- All four clients request at once from reset -> grants in order 0,1,2,3, each with its own address. Exactly 4 ack pulses, never two bits set at once.
- Client 0 re-requests immediately after every ack while client 3 also requests -> service alternates 0,3,0,3; client 3 waits at most one transaction.
- Engine holds done high for 3 cycles after rd_start drops -> arbiter remains in RELEASE for 3 cycles; next rd_start does not rise until done is low.
- Reset asserted mid-BUSY -> rd_start, ack and busy go to 0 asynchronously; the pointer returns to 0 and the next grant goes to the lowest requesting index.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, engine never asserts done -> ack for the granted client after 100 BUSY cycles with resp_err=1 and resp_data=0; rd_start drops.
